// File: rtl/ysyx_22050612_lsu_if.sv
// Handshake/bus bundle for the load/store unit.
// Execute side: in_valid/in_ready plus op fields (wen, size, unsigned,
// addr, wdata, rd). Memory side: request (valid/ready, addr, wen, wdata,
// wmask) and one-cycle response (resp_valid, rdata). Writeback side:
// out_valid/out_ready plus result (rd, wen, data, misalign, timeout).
// slave is the LSU view; master is the surrounding pipeline/memory view.
interface ysyx_22050612_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [63:0] out_data;
    logic        out_misalign;
    logic        out_timeout;

    modport slave (
        input  in_valid, in_wen, in_size, in_unsigned,
        input  in_addr, in_wdata, in_rd,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        input  out_ready,
        output in_ready,
        output mem_req_valid, mem_addr, mem_wen,
        output mem_wdata, mem_wmask,
        output out_valid, out_rd, out_wen, out_data,
        output out_misalign, out_timeout
    );

    modport master (
        output in_valid, in_wen, in_size, in_unsigned,
        output in_addr, in_wdata, in_rd,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        output out_ready,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_wen,
        input  mem_wdata, mem_wmask,
        input  out_valid, out_rd, out_wen, out_data,
        input  out_misalign, out_timeout
    );
endinterface

// File: rtl/ysyx_22050612_lsu.sv
// Load/store unit: one aligned 64-bit memory request per op, lane
// extraction and sign/zero extension of loads, misalign/timeout flags.
// Ports: clk, rst (sync, active-high), bus (ysyx_22050612_lsu_if.slave).
// TIMEOUT: number of WAIT cycles allowed for mem_resp_valid (>=1).
module ysyx_22050612_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_22050612_lsu_if.slave     bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [2:0]    off_q;
    logic          wen_q;

    logic [2:0]    amask;
    logic [7:0]    bmask;
    logic          misalign;
    logic [63:0]   raw;
    logic [63:0]   ld_val;

    assign bus.in_ready      = (state == IDLE);
    assign bus.mem_req_valid = (state == REQ);
    assign bus.out_valid     = (state == DONE);

    // Alignment mask and byte-lane pattern for the incoming size.
    always_comb begin
        amask = 3'b000;
        bmask = 8'h00;
        unique case (bus.in_size)
            2'd0: begin amask = 3'b000; bmask = 8'h01; end
            2'd1: begin amask = 3'b001; bmask = 8'h03; end
            2'd2: begin amask = 3'b011; bmask = 8'h0F; end
            2'd3: begin amask = 3'b111; bmask = 8'hFF; end
        endcase
    end

    assign misalign = |(bus.in_addr[2:0] & amask);

    // Bring the addressed lane down to bit 0, then truncate and extend.
    always_comb begin
        raw    = bus.mem_rdata >> {off_q, 3'b000};
        ld_val = raw;
        unique case (size_q)
            2'd0: ld_val = uns_q ? {56'd0, raw[7:0]}
                                 : {{56{raw[7]}}, raw[7:0]};
            2'd1: ld_val = uns_q ? {48'd0, raw[15:0]}
                                 : {{48{raw[15]}}, raw[15:0]};
            2'd2: ld_val = uns_q ? {32'd0, raw[31:0]}
                                 : {{32{raw[31]}}, raw[31:0]};
            2'd3: ld_val = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            size_q           <= 2'd0;
            uns_q            <= 1'b0;
            off_q            <= 3'd0;
            wen_q            <= 1'b0;
            bus.mem_addr     <= 64'd0;
            bus.mem_wen      <= 1'b0;
            bus.mem_wdata    <= 64'd0;
            bus.mem_wmask    <= 8'h00;
            bus.out_rd       <= 5'd0;
            bus.out_wen      <= 1'b0;
            bus.out_data     <= 64'd0;
            bus.out_misalign <= 1'b0;
            bus.out_timeout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        size_q           <= bus.in_size;
                        uns_q            <= bus.in_unsigned;
                        off_q            <= bus.in_addr[2:0];
                        wen_q            <= bus.in_wen;
                        bus.out_rd       <= bus.in_rd;
                        bus.out_wen      <= 1'b0;
                        bus.out_data     <= 64'd0;
                        bus.out_timeout  <= 1'b0;
                        bus.out_misalign <= misalign;
                        bus.mem_addr     <= {bus.in_addr[63:3], 3'b000};
                        bus.mem_wen      <= bus.in_wen;
                        bus.mem_wdata    <= bus.in_wdata
                                            << {bus.in_addr[2:0], 3'b000};
                        bus.mem_wmask    <= bus.in_wen
                                            ? bmask << bus.in_addr[2:0]
                                            : 8'h00;
                        state            <= misalign ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A response in the final counted cycle still wins.
                    if (bus.mem_resp_valid) begin
                        state <= DONE;
                        if (!wen_q && (bus.out_rd != 5'd0)) begin
                            bus.out_wen  <= 1'b1;
                            bus.out_data <= ld_val;
                        end
                    end else if (cnt == TLAST) begin
                        bus.out_timeout <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
